bus_arbiter: RTL and testbench

//  Shares the single 16-bit memory-mapped bus (inst mem, LED reg, seg7, SW reg)

---
 rtl/bus_arbiter_pkg.sv | 24 ++
 rtl/bus_arbiter_rr_arbiter.sv | 36 +++
 rtl/bus_arbiter.sv | 119 +++++++++++
 tb/tb_bus_arbiter.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/bus_arbiter_pkg.sv
// Shared types and constants for the memory-bus arbiter and the top-level address decode.
// Holds the arbiter FSM state encoding and the bus address map.
package bus_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_WAIT   = 2'd2,
        ST_DONE   = 2'd3
    } arb_state_t;

    // Region selects in the top address nibble, consumed by the top-level decode
    localparam logic [3:0] MAP_INST_MEM = 4'h0;
    localparam logic [3:0] MAP_LED      = 4'h1;
    localparam logic [3:0] MAP_SEG7     = 4'h2;
    localparam logic [3:0] MAP_SW       = 4'h3;

    localparam int CNT_W = 3;

    function automatic logic [3:0] map_region(input logic [15:0] addr);
        return addr[15:12];
    endfunction

endpackage

// File: rtl/bus_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first requester after ptr, wrapping modulo N.
// Produces the winner as one-hot, as an index, and a valid flag.
module rr_arbiter #(
    parameter int N  = 2,
    parameter int IW = 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  win_onehot,
    output logic [IW-1:0] win_idx,
    output logic          win_valid
);

    // Scan ptr+1, ptr+2, ... so the last winner has the lowest priority
    always_comb begin
        int             cand;
        logic [IW-1:0]  cand_idx;
        win_onehot = '0;
        win_idx    = '0;
        win_valid  = 1'b0;
        cand       = 0;
        cand_idx   = '0;
        for (int k = 1; k <= N; k++) begin
            cand     = (int'(ptr) + k) % N;
            cand_idx = IW'(cand);
            if (!win_valid && req[cand_idx]) begin
                win_valid            = 1'b1;
                win_onehot[cand_idx] = 1'b1;
                win_idx              = cand_idx;
            end else begin
                win_valid = win_valid;
            end
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin arbiter sharing the single memory-mapped bus among N masters,
// one transaction at a time, with RD_LAT wait cycles for synchronous slaves.
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int N      = 2,
    parameter int AW     = 16,
    parameter int DW     = 16,
    parameter int RD_LAT = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    req,
    input  logic [N-1:0]    we,
    input  logic [N*AW-1:0] addr_in,
    input  logic [N*DW-1:0] wdata_in,
    output logic [N-1:0]    gnt,
    output logic [N-1:0]    ack,
    output logic [DW-1:0]   rdata,
    output logic [AW-1:0]   bus_addr,
    output logic [DW-1:0]   bus_dout,
    output logic            bus_w,
    input  logic [DW-1:0]   bus_din,
    output logic            busy
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = (RD_LAT > 0) ? CNT_W'(RD_LAT - 1) : '0;

    arb_state_t        state_r;
    logic [IW-1:0]     ptr_r;
    logic [CNT_W-1:0]  cnt_r;
    logic              we_r;
    logic [N-1:0]      win_onehot_s;
    logic [IW-1:0]     win_idx_s;
    logic              win_valid_s;

    rr_arbiter #(.N(N), .IW(IW)) u_rr (
        .req        (req),
        .ptr        (ptr_r),
        .win_onehot (win_onehot_s),
        .win_idx    (win_idx_s),
        .win_valid  (win_valid_s)
    );

    // Transaction FSM; gnt doubles as the owner record, bus_addr/bus_dout as the latched request
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            ptr_r    <= IW'(N - 1);
            cnt_r    <= '0;
            we_r     <= 1'b0;
            gnt      <= '0;
            ack      <= '0;
            rdata    <= '0;
            bus_addr <= '0;
            bus_dout <= '0;
            bus_w    <= 1'b0;
            busy     <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    ack <= '0;
                    if (win_valid_s) begin
                        bus_addr <= addr_in[int'(win_idx_s)*AW +: AW];
                        bus_dout <= wdata_in[int'(win_idx_s)*DW +: DW];
                        we_r     <= we[win_idx_s];
                        bus_w    <= we[win_idx_s];
                        gnt      <= win_onehot_s;
                        ptr_r    <= win_idx_s;
                        busy     <= 1'b1;
                        state_r  <= ST_ACCESS;
                    end else begin
                        gnt   <= '0;
                        bus_w <= 1'b0;
                        busy  <= 1'b0;
                    end
                end
                ST_ACCESS: begin
                    bus_w <= 1'b0;
                    if (we_r) begin
                        ack     <= gnt;
                        state_r <= ST_DONE;
                    end else if (RD_LAT == 0) begin
                        rdata   <= bus_din;
                        ack     <= gnt;
                        state_r <= ST_DONE;
                    end else begin
                        cnt_r   <= CNT_INIT;
                        state_r <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (cnt_r == '0) begin
                        rdata   <= bus_din;
                        ack     <= gnt;
                        state_r <= ST_DONE;
                    end else begin
                        cnt_r <= cnt_r - 1'b1;
                    end
                end
                ST_DONE: begin
                    ack     <= '0;
                    gnt     <= '0;
                    busy    <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    ack     <= '0;
                    gnt     <= '0;
                    bus_w   <= 1'b0;
                    busy    <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: three builds (RD_LAT 0/1/3) with a scoreboard
// of expected transaction owners and read data for the RD_LAT=1 instance.
module tb_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req, req0, req3, we;
    logic [31:0] addr_in, wdata_in;

    logic [1:0]  gnt1, ack1, gnt0, ack0, gnt3, ack3;
    logic [15:0] rdata1, bus_addr1, bus_dout1, din1;
    logic [15:0] rdata0, bus_addr0, bus_dout0, din0;
    logic [15:0] rdata3, bus_addr3, bus_dout3, din3, d3a, d3b;
    logic        bus_w1, busy1, bus_w0, busy0, bus_w3, busy3;

    typedef struct {
        int          idx;
        bit          wr;
        logic [15:0] rdata;
    } exp_t;
    exp_t sb[$];

    int total = 0;
    int bad   = 0;
    int bw_cnt = 0;

    always #5 clk = ~clk;

    function automatic logic [15:0] slave_f(input logic [15:0] a);
        return (a == 16'h0004) ? 16'hBEEF : (a ^ 16'h5A5A);
    endfunction

    assign din0 = slave_f(bus_addr0);
    always @(posedge clk) din1 <= slave_f(bus_addr1);
    always @(posedge clk) begin
        d3a  <= slave_f(bus_addr3);
        d3b  <= d3a;
        din3 <= d3b;
    end

    bus_arbiter #(.N(2), .AW(16), .DW(16), .RD_LAT(1)) dut1 (
        .clk(clk), .rst(rst), .req(req), .we(we), .addr_in(addr_in), .wdata_in(wdata_in),
        .gnt(gnt1), .ack(ack1), .rdata(rdata1), .bus_addr(bus_addr1), .bus_dout(bus_dout1),
        .bus_w(bus_w1), .bus_din(din1), .busy(busy1));

    bus_arbiter #(.N(2), .AW(16), .DW(16), .RD_LAT(0)) dut0 (
        .clk(clk), .rst(rst), .req(req0), .we(we), .addr_in(addr_in), .wdata_in(wdata_in),
        .gnt(gnt0), .ack(ack0), .rdata(rdata0), .bus_addr(bus_addr0), .bus_dout(bus_dout0),
        .bus_w(bus_w0), .bus_din(din0), .busy(busy0));

    bus_arbiter #(.N(2), .AW(16), .DW(16), .RD_LAT(3)) dut3 (
        .clk(clk), .rst(rst), .req(req3), .we(we), .addr_in(addr_in), .wdata_in(wdata_in),
        .gnt(gnt3), .ack(ack3), .rdata(rdata3), .bus_addr(bus_addr3), .bus_dout(bus_dout3),
        .bus_w(bus_w3), .bus_din(din3), .busy(busy3));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Scoreboard monitor for the RD_LAT=1 instance, sampled just after each rising edge
    always @(posedge clk) begin
        #1;
        if (bus_w1 === 1'b1) bw_cnt++;
        chk("gnt_onehot0", {31'b0, $onehot0(gnt1)}, 32'd1);
        if (ack1 !== 2'b00) begin
            if (sb.size() == 0) begin
                chk("unexpected_ack", {30'b0, ack1}, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("ack_owner", {30'b0, ack1}, 32'd1 << e.idx);
                chk("gnt_at_ack", {30'b0, gnt1}, 32'd1 << e.idx);
                if (!e.wr) chk("sb_rdata", {16'b0, rdata1}, {16'b0, e.rdata});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        int n, done_at, a0, a1, a3;
        rst = 1'b1; req = 2'b00; req0 = 2'b00; req3 = 2'b00; we = 2'b00;
        addr_in = 32'h0; wdata_in = 32'h0;
        repeat (3) @(negedge clk);
        chk("rst_gnt", {30'b0, gnt1}, 32'd0);
        chk("rst_ack", {30'b0, ack1}, 32'd0);
        chk("rst_bus_w", {31'b0, bus_w1}, 32'd0);
        chk("rst_busy", {31'b0, busy1}, 32'd0);
        chk("rst_rdata", {16'b0, rdata1}, 32'd0);
        chk("rst_bus_addr", {16'b0, bus_addr1}, 32'd0);
        chk("rst_bus_dout", {16'b0, bus_dout1}, 32'd0);
        rst = 1'b0;

        // single write from m0; request fields changed after grant must be ignored
        req = 2'b01; we = 2'b01; addr_in[15:0] = 16'h1000; wdata_in[15:0] = 16'h01A5; bw_cnt = 0;
        sb.push_back('{0, 1'b1, 16'h0000});
        @(negedge clk);
        chk("w_gnt", {30'b0, gnt1}, 32'd1);
        chk("w_bus_w", {31'b0, bus_w1}, 32'd1);
        chk("w_addr", {16'b0, bus_addr1}, 32'h1000);
        chk("w_dout", {16'b0, bus_dout1}, 32'h01A5);
        chk("w_busy", {31'b0, busy1}, 32'd1);
        chk("w_ack_early", {30'b0, ack1}, 32'd0);
        addr_in[15:0] = 16'hFFFF; wdata_in[15:0] = 16'hFFFF;
        @(negedge clk);
        chk("w_ack", {30'b0, ack1}, 32'd1);
        chk("w_bus_w_off", {31'b0, bus_w1}, 32'd0);
        chk("w_addr_hold", {16'b0, bus_addr1}, 32'h1000);
        req = 2'b00;
        @(negedge clk);
        chk("w_idle_busy", {31'b0, busy1}, 32'd0);
        chk("w_idle_gnt", {30'b0, gnt1}, 32'd0);
        chk("w_pulses", bw_cnt, 32'd1);

        // single read from m1 with one wait cycle
        bw_cnt = 0; req = 2'b10; we = 2'b00; addr_in[31:16] = 16'h0004;
        sb.push_back('{1, 1'b0, 16'hBEEF});
        @(negedge clk);
        chk("r_gnt", {30'b0, gnt1}, 32'd2);
        chk("r_addr", {16'b0, bus_addr1}, 32'h0004);
        @(negedge clk);
        chk("r_ack_wait", {30'b0, ack1}, 32'd0);
        @(negedge clk);
        chk("r_ack", {30'b0, ack1}, 32'd2);
        chk("r_rdata", {16'b0, rdata1}, 32'hBEEF);
        req = 2'b00;
        @(negedge clk);
        chk("r_idle_busy", {31'b0, busy1}, 32'd0);
        chk("r_no_bus_w", bw_cnt, 32'd0);

        // contention from reset: m0 write, m1 read, alternating 0,1,0,1
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bw_cnt = 0; req = 2'b11; we = 2'b01;
        addr_in = {16'h0008, 16'h3000}; wdata_in = {16'h0000, 16'hAAAA};
        sb.push_back('{0, 1'b1, 16'h0000});
        sb.push_back('{1, 1'b0, 16'h5A52});
        sb.push_back('{0, 1'b1, 16'h0000});
        sb.push_back('{1, 1'b0, 16'h5A52});
        n = 0; done_at = 0;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            if (ack1 !== 2'b00) n++;
            if (n == 4) begin
                done_at = i;
                req = 2'b00;
                break;
            end
        end
        chk("rr_ack_count", n, 32'd4);
        chk("rr_done_cycle", done_at, 32'd13);
        @(negedge clk);
        chk("rr_write_pulses", bw_cnt, 32'd2);

        // requester drops req during ACCESS; transaction still completes
        bw_cnt = 0; req = 2'b01; we = 2'b01; addr_in[15:0] = 16'h2000; wdata_in[15:0] = 16'h1234;
        sb.push_back('{0, 1'b1, 16'h0000});
        @(negedge clk);
        chk("drop_bus_w", {31'b0, bus_w1}, 32'd1);
        chk("drop_dout", {16'b0, bus_dout1}, 32'h1234);
        req = 2'b00;
        @(negedge clk);
        chk("drop_ack", {30'b0, ack1}, 32'd1);
        @(negedge clk);
        chk("drop_pulses", bw_cnt, 32'd1);
        chk("drop_rdata_kept", {16'b0, rdata1}, 32'h5A52);

        // reset while m1 read is waiting: aborted, then m0 wins the simultaneous request
        req = 2'b10; we = 2'b00; addr_in[31:16] = 16'h0010;
        @(negedge clk);
        chk("rw_gnt", {30'b0, gnt1}, 32'd2);
        @(negedge clk);
        chk("rw_busy", {31'b0, busy1}, 32'd1);
        rst = 1'b1; req = 2'b11; we = 2'b11; addr_in[15:0] = 16'h4000; wdata_in[15:0] = 16'h5555;
        @(negedge clk);
        chk("rw_ack", {30'b0, ack1}, 32'd0);
        chk("rw_gnt0", {30'b0, gnt1}, 32'd0);
        chk("rw_busy0", {31'b0, busy1}, 32'd0);
        chk("rw_bus_w0", {31'b0, bus_w1}, 32'd0);
        chk("rw_addr0", {16'b0, bus_addr1}, 32'd0);
        chk("rw_rdata0", {16'b0, rdata1}, 32'd0);
        rst = 1'b0;
        sb.push_back('{0, 1'b1, 16'h0000});
        @(negedge clk);
        chk("rw_regrant", {30'b0, gnt1}, 32'd1);
        chk("rw_regrant_addr", {16'b0, bus_addr1}, 32'h4000);
        @(negedge clk);
        chk("rw_regrant_ack", {30'b0, ack1}, 32'd1);
        req = 2'b00;
        @(negedge clk);
        chk("rw_idle", {31'b0, busy1}, 32'd0);

        // read latency across RD_LAT = 0, 1, 3 builds
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        req = 2'b01; req0 = 2'b01; req3 = 2'b01; we = 2'b00; addr_in[15:0] = 16'h0004;
        sb.push_back('{0, 1'b0, 16'hBEEF});
        a0 = 0; a1 = 0; a3 = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (ack0 !== 2'b00 && a0 == 0) begin a0 = i; req0 = 2'b00; end
            if (ack1 !== 2'b00 && a1 == 0) begin a1 = i; req  = 2'b00; end
            if (ack3 !== 2'b00 && a3 == 0) begin a3 = i; req3 = 2'b00; end
        end
        chk("lat0_ack_cycle", a0, 32'd2);
        chk("lat1_ack_cycle", a1, 32'd3);
        chk("lat3_ack_cycle", a3, 32'd5);
        chk("lat0_rdata", {16'b0, rdata0}, 32'hBEEF);
        chk("lat3_rdata", {16'b0, rdata3}, 32'hBEEF);
        chk("sb_drained", sb.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
